trainled_frame_tx: RTL and testbench
====================================

TRAINLED_FRAME_TX -- requirements
Module: trainled_frame_tx

Interface
REQ-001 Parameter RESET_CYCLES, 128, line-low clocks appended after each frame; legal range 100..255.
REQ-002 Parameter UNDERRUN_LIMIT, 80, max mid-frame line-low stall clocks before abort (used only with macro); legal range 1..90.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  12  pixel word; [11:8]=LED3, [7:4]=LED2, [3:0]=LED1 PWM values.
REQ-006 in_last  input  1  qualifies in_data as final word of frame.
REQ-007 in_valid  input  1  word offered.
REQ-008 in_ready  output  1  word accepted on a clock edge where in_valid&&in_ready.
REQ-009 dout  output  1  registered serial line to first LED in chain.
REQ-010 busy  output  1  high whenever state != IDLE.
REQ-011 frame_done  output  1  one-cycle pulse when GAP completes.
REQ-012 underrun_err  output  1  sticky mid-frame abort flag.

Function
REQ-013 Bit cell is 12 clocks, tick 0..11: dout=1 ticks 0-3, dout=data bit ticks 4-7, dout=0 ticks 8-11.
REQ-014 Word sent MSB first (bit 11 first), 12 cells, 144 clocks per word, no idle clocks between consecutive words when next word is already held.
REQ-015 One-entry holding register (data+last); in_ready = holding empty AND no in_last word accepted since last IDLE.
REQ-016 Shift register loads from holding register at tick 11 of bit 0 of current word, or on the cycle after acceptance when state is IDLE or WAIT.
REQ-017 Latency: word accepted at edge N in IDLE -> dout first high after edge N+2.
REQ-018 States: IDLE (dout=0), SEND (emitting cells), WAIT (mid-frame, holding empty, dout=0), GAP (dout=0 for RESET_CYCLES clocks).
REQ-019 IDLE->SEND on load; SEND->SEND at word end if holding full; SEND->GAP at word end if sent word had in_last; SEND->WAIT at word end otherwise; WAIT->SEND on load; GAP->IDLE after RESET_CYCLES clocks, asserting frame_done that cycle.
REQ-020 in_valid dropping while in_ready low is a protocol violation; behaviour unspecified.
REQ-021 Simultaneous acceptance and shift-register load from holding in the same cycle: new word enters holding register, loaded word leaves; no loss.
REQ-022 Gap counter 8 bits, saturating at RESET_CYCLES, cleared on GAP entry.

Reset
REQ-023 On rst: state=IDLE, dout=0, in_ready=1 (following cycle), busy=0, frame_done=0, underrun_err=0, holding empty, tick/bit/gap counters 0.
REQ-024 rst mid-word truncates cell immediately; no GAP emitted; downstream re-syncs via its own idle timeout.

Configuration
REQ-025 Macro TRAINLED_TX_UNDERRUN_EN defined: WAIT counts clocks; at UNDERRUN_LIMIT -> GAP, set underrun_err, drop any subsequent words until IDLE (in_ready held low); underrun_err clears on next acceptance from IDLE.
REQ-026 Macro undefined: WAIT lasts indefinitely; underrun_err tied 0; port retained.

Structure
REQ-027 Shared package trainled_pkg: BIT_TICKS=12, WORD_BITS=12, PHASE_HI_END=4, PHASE_DATA_END=8, RX_RESET_TIMEOUT=96, state enum.
REQ-028 One sub-module trainled_bit_enc: tick counter + phase mux, inputs bit value/enable, outputs dout_next and cell_end.

Verification
REQ-029 Single word 0xA5C with in_last -> dout = 144 clocks of cells 1,0,1,0,0,1,0,1,1,1,0,0 then 128 low clocks, frame_done pulse, busy low.
REQ-030 Three back-to-back words held ready -> 432 contiguous cell clocks, no extra low clocks between words; in_ready pattern allows acceptance one word ahead.
REQ-031 Chain of three team TrainLED receivers driven by dout, frame 0x321,0x654,0x987 -> after gap, LED latches hold 0x987,0x654,0x321 nearest-first order verified against receiver forwarding.
REQ-032 Macro on: first word sent, in_valid withheld 80 clocks -> GAP entered, underrun_err=1, frame_done after 128 low clocks; next frame clears flag.
REQ-033 Macro off: same stall of 200 clocks -> state stays WAIT, dout=0, underrun_err=0; resume sends next word.
REQ-034 rst asserted at tick 5 of bit 3 -> dout=0 next cycle, all outputs at reset values, new frame accepted normally.

Source files
------------

// File: rtl/trainled_pkg.sv
// Shared TrainLED line constants and transmitter state encoding.
// The receiver timeout is exported here so that the transmitter and any line model use the same value.
package trainled_pkg;

    localparam int BIT_TICKS        = 12;
    localparam int WORD_BITS        = 12;
    localparam int PHASE_HI_END     = 4;
    localparam int PHASE_DATA_END   = 8;
    localparam int RX_RESET_TIMEOUT = 96;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    // Cell waveform: a high lead-in, then the data bit, then a low tail.
    function automatic logic cell_level(input logic [3:0] tick, input logic data_bit);
        if (tick < 4'(PHASE_HI_END)) return 1'b1;
        if (tick < 4'(PHASE_DATA_END)) return data_bit;
        return 1'b0;
    endfunction

endpackage

// File: rtl/trainled_frame_tx_if.sv
// Pixel-word valid/ready handshake into the TrainLED frame transmitter.
interface trainled_frame_tx_if;
    logic [11:0] in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_last, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_last, input  in_valid, output in_ready);
endinterface

// File: rtl/trainled_bit_enc.sv
// Bit-cell encoder: tick counter plus phase mux producing the next line level for one cell.
module trainled_bit_enc
    import trainled_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic bit_i,
    output logic dout_next_o,
    output logic cell_end_o
);

    logic [3:0] tick_q, tick_d;

    assign cell_end_o  = en_i && (tick_q == 4'(BIT_TICKS - 1));
    assign dout_next_o = en_i && cell_level(tick_q, bit_i);

    // The counter parks at zero while disabled so every enable starts on a fresh cell.
    always_comb begin
        tick_d = tick_q;
        if (!en_i || cell_end_o) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/trainled_frame_tx.sv
// TrainLED frame transmitter: holding register feeding a serial cell encoder, then a line-low reset gap.
// Optional mid-frame underrun abort is enabled by defining TRAINLED_TX_UNDERRUN_EN.
//   state | meaning
//   IDLE  | no frame open, line low
//   SEND  | emitting bit cells of the current word
//   WAIT  | mid-frame, holding register empty, line low
//   GAP   | line held low RESET_CYCLES clocks to latch the chain
module trainled_frame_tx
    import trainled_pkg::*;
#(
    parameter int RESET_CYCLES   = 128,
    parameter int UNDERRUN_LIMIT = 80
) (
    input  logic              clk,
    input  logic              rst,
    trainled_frame_tx_if.slave s_if,
    output logic              dout,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun_err
);

    if (RESET_CYCLES < 100 || RESET_CYCLES > 255 || UNDERRUN_LIMIT < 1 || UNDERRUN_LIMIT > 90) begin : g_bad_param
        $error("trainled_frame_tx: parameter out of range");
    end

    tx_state_e   state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic [11:0] shift_q;
    logic [3:0]  bit_cnt_q;
    logic        cur_last_q;
    logic        hold_valid_q;
    logic [11:0] hold_data_q;
    logic        hold_last_q;
    logic        closed_q;
    logic        dout_q;
    logic        enc_dout;
    logic        cell_end;
    logic        word_end;
    logic        load;
    logic        accept;
    logic        abort;
    logic        frame_done_c;

`ifdef TRAINLED_TX_UNDERRUN_EN
    logic [6:0]  stall_q, stall_d;
    logic        underrun_q;
`endif

    // closed_q blocks further words once the frame's last word is in, or after an abort.
    assign s_if.in_ready = !hold_valid_q && !closed_q;
    assign accept        = s_if.in_valid && s_if.in_ready;
    assign word_end      = cell_end && (bit_cnt_q == 4'(WORD_BITS - 1));
    assign load          = hold_valid_q && ((state_q == ST_IDLE) || (state_q == ST_WAIT) ||
                                            (state_q == ST_SEND && word_end && !cur_last_q));

    assign dout       = dout_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_c;

    trainled_bit_enc u_enc (
        .clk         (clk),
        .rst         (rst),
        .en_i        (state_q == ST_SEND),
        .bit_i       (shift_q[11]),
        .dout_next_o (enc_dout),
        .cell_end_o  (cell_end)
    );

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        abort        = 1'b0;
        frame_done_c = 1'b0;
`ifdef TRAINLED_TX_UNDERRUN_EN
        stall_d      = stall_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (load) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (word_end) begin
                    if (cur_last_q) begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end else if (!hold_valid_q) begin
                        state_d = ST_WAIT;
`ifdef TRAINLED_TX_UNDERRUN_EN
                        stall_d = '0;
`endif
                    end
                end
            end
            ST_WAIT: begin
                if (load) begin
                    state_d = ST_SEND;
`ifdef TRAINLED_TX_UNDERRUN_EN
                end else if (stall_q == 7'(UNDERRUN_LIMIT - 1)) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                    abort   = 1'b1;
                end else begin
                    stall_d = stall_q + 7'd1;
`endif
                end
            end
            ST_GAP: begin
                if (gap_q == 8'(RESET_CYCLES - 1)) begin
                    state_d      = ST_IDLE;
                    frame_done_c = 1'b1;
                end else if (gap_q != 8'(RESET_CYCLES)) begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gap_q        <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            cur_last_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            closed_q     <= 1'b0;
            dout_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            dout_q  <= enc_dout;

            if (load) begin
                shift_q    <= hold_data_q;
                cur_last_q <= hold_last_q;
                bit_cnt_q  <= '0;
            end else if (cell_end) begin
                shift_q   <= {shift_q[10:0], 1'b0};
                bit_cnt_q <= word_end ? 4'd0 : bit_cnt_q + 4'd1;
            end

            // A word accepted while another is loaded out simply replaces it in the holding slot.
            if (accept) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= s_if.in_data;
                hold_last_q  <= s_if.in_last;
            end else if (load) begin
                hold_valid_q <= 1'b0;
            end

            if (frame_done_c) begin
                closed_q <= 1'b0;
            end else if ((accept && s_if.in_last) || abort) begin
                closed_q <= 1'b1;
            end
        end
    end

`ifdef TRAINLED_TX_UNDERRUN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            if (abort) begin
                underrun_q <= 1'b1;
            end else if (accept && state_q == ST_IDLE) begin
                underrun_q <= 1'b0;
            end
        end
    end
    assign underrun_err = underrun_q;
`else
    assign underrun_err = 1'b0;
`endif

endmodule

// File: tb/tb_trainled_frame_tx.sv
// Directed bench for trainled_frame_tx with a behavioural three-receiver TrainLED chain on dout.
// Define TRAINLED_TX_UNDERRUN_EN to exercise the underrun-abort build instead of the indefinite-wait build.
module tb_trainled_frame_tx;
    import trainled_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dout, busy, frame_done, underrun_err;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    trainled_frame_tx_if bus();

    trainled_frame_tx #(.RESET_CYCLES(128), .UNDERRUN_LIMIT(80)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_if         (bus.slave),
        .dout         (dout),
        .busy         (busy),
        .frame_done   (frame_done),
        .underrun_err (underrun_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Receiver chain model: decodes words off the line and, on line-low timeout, latches them
    // with forwarding semantics (each new word pushes the held one further down the chain).
    logic [11:0] rx_words[$];
    logic [11:0] led[3];
    logic        led_v[3];
    int          last_nwords = 0;

    initial begin
        int          rx_tick = 100;
        int          rx_nbits = 0;
        int          rx_low = 0;
        logic        prev_d = 1'b0;
        logic [11:0] rx_sh = '0;
        logic [11:0] hold[3];
        logic        hv[3];
        logic [11:0] carry, nxt;
        logic        cv, nv;
        for (int i = 0; i < 3; i++) begin led[i] = '0; led_v[i] = 1'b0; end
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_nbits = 0; rx_words.delete(); rx_low = 0; rx_tick = 100; prev_d = 1'b0;
            end else begin
                if (dout && !prev_d) rx_tick = 0;
                else if (rx_tick < 100) rx_tick++;
                if (rx_tick == 5) begin
                    rx_sh = {rx_sh[10:0], dout};
                    rx_nbits++;
                    if (rx_nbits == WORD_BITS) begin rx_words.push_back(rx_sh); rx_nbits = 0; end
                end
                rx_low = dout ? 0 : rx_low + 1;
                if (rx_low == RX_RESET_TIMEOUT) begin
                    if (rx_words.size() > 0) begin
                        for (int i = 0; i < 3; i++) begin hold[i] = '0; hv[i] = 1'b0; end
                        foreach (rx_words[k]) begin
                            carry = rx_words[k]; cv = 1'b1;
                            for (int i = 0; i < 3; i++) begin
                                if (cv) begin
                                    nxt = hold[i]; nv = hv[i];
                                    hold[i] = carry; hv[i] = 1'b1;
                                    carry = nxt; cv = nv;
                                end
                            end
                        end
                        for (int i = 0; i < 3; i++) begin led[i] = hold[i]; led_v[i] = hv[i]; end
                        last_nwords = rx_words.size();
                    end
                    rx_words.delete();
                    rx_nbits = 0;
                end
                prev_d = dout;
            end
        end
    end

    // Expected line level s clocks into the cell stream of word w.
    function automatic logic exp_cell(input logic [11:0] w, input int s);
        int t;
        int b;
        t = s % 12;
        b = 11 - (s / 12);
        if (t < 4) return 1'b1;
        if (t < 8) return w[b];
        return 1'b0;
    endfunction

    task automatic push_word(input logic [11:0] d, input logic last, output int acc);
        int   n;
        logic took;
        n = 0;
        took = 1'b0;
        acc = -1;
        bus.in_data = d; bus.in_last = last; bus.in_valid = 1'b1;
        do begin
            took = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!took && n < 1000);
        if (took) acc = cyc;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        checks++;
        if (took !== 1'b1) begin
            errors++;
            $display("FAIL push_accept: word %h accepted=%b required=1", d, took);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dout, busy, frame_done, underrun_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: dout/busy/done/err=%b required 0000", {dout, busy, frame_done, underrun_err});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_single();
        int acc, n, bad_cell, bad_low, bad_done, bad_busy;
        push_word(12'hA5C, 1'b1, acc);
        n = 0;
        while (dout !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL single_latency: got %0d clocks required 2", n); end
        bad_cell = 0; bad_low = 0; bad_done = 0; bad_busy = 0;
        for (int s = 0; s < 272; s++) begin
            if (s < 144) begin
                if (dout !== exp_cell(12'hA5C, s)) bad_cell++;
            end else if (dout !== 1'b0) bad_low++;
            if (frame_done !== (s == 270)) bad_done++;
            if (busy !== (s <= 270)) bad_busy++;
            if (s < 271) begin @(posedge clk); #1; end
        end
        checks++;
        if (bad_cell != 0) begin errors++; $display("FAIL single_cells: %0d wrong clocks required 0", bad_cell); end
        checks++;
        if (bad_low != 0) begin errors++; $display("FAIL single_gap_low: %0d high clocks required 0", bad_low); end
        checks++;
        if (bad_done != 0) begin errors++; $display("FAIL single_frame_done: %0d wrong clocks required 0", bad_done); end
        checks++;
        if (bad_busy != 0) begin errors++; $display("FAIL single_busy: %0d wrong clocks required 0", bad_busy); end
        checks++;
        if (led[0] !== 12'hA5C || last_nwords !== 1) begin
            errors++;
            $display("FAIL single_rx: led0=%h words=%0d required a5c 1", led[0], last_nwords);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] w[3];
        int acc[3];
        int bad_cell, bad_low, done_at, n;
        logic ready_after;
        w[0] = 12'h321; w[1] = 12'h654; w[2] = 12'h987;
        bad_cell = 0; bad_low = 0; done_at = -1; n = 0; ready_after = 1'bx;
        fork
            begin
                for (int k = 0; k < 3; k++) push_word(w[k], (k == 2), acc[k]);
                ready_after = bus.in_ready;
            end
            begin
                while (dout !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
                for (int s = 0; s < 560; s++) begin
                    if (s < 432) begin
                        if (dout !== exp_cell(w[s / 144], s % 144)) bad_cell++;
                    end else if (dout !== 1'b0) bad_low++;
                    if (frame_done === 1'b1 && done_at < 0) done_at = s;
                    @(posedge clk); #1;
                end
            end
        join
        checks++;
        if (bad_cell != 0) begin errors++; $display("FAIL b2b_cells: %0d wrong clocks required 0", bad_cell); end
        checks++;
        if (bad_low != 0) begin errors++; $display("FAIL b2b_gap_low: %0d high clocks required 0", bad_low); end
        checks++;
        if (done_at !== 558) begin errors++; $display("FAIL b2b_frame_done: at %0d required 558", done_at); end
        checks++;
        if (acc[1] - acc[0] !== 2 || acc[2] - acc[0] !== 146) begin
            errors++;
            $display("FAIL b2b_accept_timing: deltas %0d %0d required 2 146", acc[1] - acc[0], acc[2] - acc[0]);
        end
        checks++;
        if (ready_after !== 1'b0) begin errors++; $display("FAIL b2b_ready_after_last: got %b required 0", ready_after); end
        checks++;
        if (led[0] !== 12'h987 || led[1] !== 12'h654 || led[2] !== 12'h321 || last_nwords !== 3) begin
            errors++;
            $display("FAIL chain_leds: %h %h %h words=%0d required 987 654 321 3", led[0], led[1], led[2], last_nwords);
        end
    endtask

`ifdef TRAINLED_TX_UNDERRUN_EN
    task automatic test_underrun();
        int acc, n, acc2;
        push_word(12'h0F0, 1'b0, acc);
        n = 0;
        while (underrun_err !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== 225) begin errors++; $display("FAIL underrun_time: got %0d clocks required 225", n); end
        checks++;
        if (bus.in_ready !== 1'b0 || busy !== 1'b1 || dout !== 1'b0) begin
            errors++;
            $display("FAIL underrun_gap: ready/busy/dout=%b required 010", {bus.in_ready, busy, dout});
        end
        while (frame_done !== 1'b1 && n < 600) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== 352) begin errors++; $display("FAIL underrun_done: got %0d clocks required 352", n); end
        @(posedge clk); #1;
        push_word(12'h00F, 1'b1, acc2);
        checks++;
        if (underrun_err !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b required 0", underrun_err); end
        n = 0;
        while (frame_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL underrun_next_frame: no frame_done"); end
        @(posedge clk); #1;
    endtask
`else
    task automatic test_stall();
        int acc, n, bad;
        push_word(12'h0F0, 1'b0, acc);
        repeat (150) @(posedge clk);
        #1;
        bad = 0;
        for (int s = 0; s < 200; s++) begin
            if (dout !== 1'b0 || busy !== 1'b1 || underrun_err !== 1'b0 || bus.in_ready !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_wait: %0d wrong clocks required 0", bad); end
        push_word(12'h00F, 1'b1, acc);
        n = 0;
        while (dout !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL stall_resume_latency: got %0d required 2", n); end
        n = 0;
        while (frame_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        checks++;
        if (frame_done !== 1'b1 || underrun_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_finish: done=%b err=%b required 1 0", frame_done, underrun_err);
        end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_reset_mid_word();
        int acc, n;
        push_word(12'h5A5, 1'b1, acc);
        n = 0;
        while (dout !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        repeat (41) @(posedge clk);
        #1;
        checks++;
        if (dout !== 1'b1) begin errors++; $display("FAIL midrst_pre: dout=%b required 1", dout); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({dout, busy, frame_done, underrun_err, bus.in_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL midrst_outputs: dout/busy/done/err/ready=%b required 00001",
                     {dout, busy, frame_done, underrun_err, bus.in_ready});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        push_word(12'h123, 1'b1, acc);
        n = 0;
        while (dout !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL midrst_latency: got %0d required 2", n); end
        n = 0;
        while (frame_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        checks++;
        if (frame_done !== 1'b1 || led[0] !== 12'h123 || last_nwords !== 1) begin
            errors++;
            $display("FAIL midrst_frame: done=%b led0=%h words=%0d required 1 123 1", frame_done, led[0], last_nwords);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_data = '0; bus.in_last = 1'b0; bus.in_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
`ifdef TRAINLED_TX_UNDERRUN_EN
        test_underrun();
`else
        test_stall();
`endif
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
